// File: rtl/adder_bist_pkg.sv
// Shared types and helpers for the adder built-in self-test engine.
package adder_bist_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} bist_state_t;

  function automatic int unsigned n_vec(input int unsigned w);
    return 32'd1 << (2 * w);
  endfunction

endpackage

// File: rtl/adder_golden.sv
// Golden reference for the adder under test: full-width sum with carry-out.
module adder_golden #(
  parameter int unsigned OPERAND_W = 1
) (
  input  logic [OPERAND_W-1:0] a,
  input  logic [OPERAND_W-1:0] b,
  output logic [OPERAND_W-1:0] sum,
  output logic                 carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_bist.sv
// Exhaustive self-test sequencer for small adders: drives every operand pair,
// waits SETTLE_CYCLES, compares against adder_golden and records failures.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter int unsigned OPERAND_W     = 1,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  output logic [OPERAND_W-1:0]   a_o,
  output logic [OPERAND_W-1:0]   b_o,
  input  logic [OPERAND_W-1:0]   sum_i,
  input  logic                   carry_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [2*OPERAND_W:0]   err_cnt_o,
  output logic                   fail_seen_o,
  output logic [2*OPERAND_W-1:0] first_fail_o
);

  localparam int unsigned IDX_W = 2 * OPERAND_W;
  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned N_VEC = n_vec(OPERAND_W);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_VEC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  bist_state_t       state;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  settle_cnt;
  logic [OPERAND_W-1:0] gold_sum;
  logic              gold_carry;
  logic              mismatch;

  adder_golden #(.OPERAND_W(OPERAND_W)) u_golden (
    .a     (a_o),
    .b     (b_o),
    .sum   (gold_sum),
    .carry (gold_carry)
  );

  // Operands come straight from the index register, so they only move with idx.
  assign a_o      = idx[IDX_W-1:OPERAND_W];
  assign b_o      = idx[OPERAND_W-1:0];
  assign mismatch = ({carry_i, sum_i} != {gold_carry, gold_sum});
  assign pass_o   = done_o && (err_cnt_o == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      idx          <= '0;
      settle_cnt   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_cnt_o    <= '0;
      fail_seen_o  <= 1'b0;
      first_fail_o <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_i) begin
            idx          <= '0;
            settle_cnt   <= '0;
            err_cnt_o    <= '0;
            fail_seen_o  <= 1'b0;
            first_fail_o <= '0;
            done_o       <= 1'b0;
            busy_o       <= 1'b1;
            state        <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (mismatch) begin
            if (err_cnt_o != '1) begin
              err_cnt_o <= err_cnt_o + 1'b1;
            end
            if (!fail_seen_o) begin
              fail_seen_o  <= 1'b1;
              first_fail_o <= idx;
            end
          end
          if (idx == LAST_IDX) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            idx        <= idx + 1'b1;
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
